wb_write_queue: RTL and testbench



---
 rtl/wb_write_queue_pkg.sv | 10 +
 rtl/wb_write_queue_if.sv | 26 ++
 rtl/wbq_lookup.sv | 30 +++
 rtl/wb_write_queue.sv | 61 ++++++
 tb/tb_wb_write_queue.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/wb_write_queue_pkg.sv
// wb_write_queue_pkg: shared widths and the queue entry type for the writeback queue
package wb_write_queue_pkg;
  localparam int REG_W = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_W-1:0] ZERO_REG = '0;
  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wbq_entry_t;
endpackage

// File: rtl/wb_write_queue_if.sv
// wb_write_queue_if: request, drain and forwarding-lookup signals of the writeback queue
interface wb_write_queue_if #(parameter int N = 32, parameter int DEPTH = 4);
  logic in_valid;
  logic in_ready;
  logic [4:0] in_rd;
  logic [N-1:0] in_data;
  logic hold;
  logic [4:0] Rw;
  logic [N-1:0] Di;
  logic WE;
  logic [4:0] Qa;
  logic [4:0] Qb;
  logic hitA;
  logic hitB;
  logic [N-1:0] fwdA;
  logic [N-1:0] fwdB;
  logic [$clog2(DEPTH):0] count;
  modport master (
    output in_valid, in_rd, in_data, hold, Qa, Qb,
    input in_ready, Rw, Di, WE, hitA, hitB, fwdA, fwdB, count
  );
  modport slave (
    input in_valid, in_rd, in_data, hold, Qa, Qb,
    output in_ready, Rw, Di, WE, hitA, hitB, fwdA, fwdB, count
  );
endinterface

// File: rtl/wbq_lookup.sv
// wbq_lookup: newest-first match of one address against pending entries, then the output register
module wbq_lookup
  import wb_write_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic [REG_W-1:0]  addr_i,
  input  wbq_entry_t        ent_i [DEPTH],
  input  logic [DEPTH-1:0]  vld_i,
  input  wbq_entry_t        out_i,
  input  logic              out_vld_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] fwd_o
);
  // entries arrive oldest first, so a later match overrides an earlier one
  always_comb begin
    hit_o = out_vld_i && out_i.rd == addr_i;
    fwd_o = hit_o ? out_i.data : '0;
    for (int j = 0; j < DEPTH; j++) begin
      if (vld_i[j] && ent_i[j].rd == addr_i) begin
        hit_o = 1'b1;
        fwd_o = ent_i[j].data;
      end
    end
    if (addr_i == ZERO_REG) begin
      hit_o = 1'b0;
      fwd_o = '0;
    end
  end
endmodule

// File: rtl/wb_write_queue.sv
// wb_write_queue: FIFO of register-file writes drained one per cycle, with forwarding lookup
module wb_write_queue
  import wb_write_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  wb_write_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  wbq_entry_t mem_q [DEPTH];
  wbq_entry_t ord [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [AW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  wbq_entry_t out_q;
  logic we_q;
  logic push, pop;
  assign bus.in_ready = !rst && count_q < CW'(DEPTH);
  assign push = bus.in_valid && bus.in_ready && bus.in_rd != ZERO_REG;
  assign pop = !bus.hold && count_q != '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      out_q <= '0;
      we_q <= 1'b0;
    end else begin
      if (push) tail_q <= tail_q + 1'b1;
      if (pop) head_q <= head_q + 1'b1;
      if (pop) out_q <= mem_q[head_q];
      count_q <= count_q + CW'(push) - CW'(pop);
      we_q <= pop;
    end
  end
  // storage needs no reset: occupancy is defined by count alone
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= '{rd: bus.in_rd, data: bus.in_data};
  end
  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      ord[j] = mem_q[head_q + AW'(j)];
      vld[j] = CW'(j) < count_q;
    end
  end
  wbq_lookup #(.DEPTH(DEPTH)) u_lookup_a (
    .addr_i(bus.Qa), .ent_i(ord), .vld_i(vld), .out_i(out_q), .out_vld_i(we_q),
    .hit_o(bus.hitA), .fwd_o(bus.fwdA)
  );
  wbq_lookup #(.DEPTH(DEPTH)) u_lookup_b (
    .addr_i(bus.Qb), .ent_i(ord), .vld_i(vld), .out_i(out_q), .out_vld_i(we_q),
    .hit_o(bus.hitB), .fwd_o(bus.fwdB)
  );
  assign bus.Rw = out_q.rd;
  assign bus.Di = out_q.data;
  assign bus.WE = we_q;
  assign bus.count = count_q;
endmodule

// File: tb/tb_wb_write_queue.sv
// tb_wb_write_queue: directed scenario tests of the writeback write queue
module tb_wb_write_queue;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] rf [32];
  int total = 0;
  int passed = 0;
  wb_write_queue_if #(.N(32), .DEPTH(4)) bus ();
  wb_write_queue #(.DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.WE) rf[bus.Rw] <= bus.Di;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++; if (bus.in_ready !== 1'b0) $display("FAIL rst_ready got %b exp 0", bus.in_ready); else passed++;
    total++; if (bus.WE !== 1'b0) $display("FAIL rst_we got %b exp 0", bus.WE); else passed++;
    total++; if (bus.Rw !== 5'd0) $display("FAIL rst_rw got %0d exp 0", bus.Rw); else passed++;
    total++; if (bus.Di !== 32'd0) $display("FAIL rst_di got %h exp 0", bus.Di); else passed++;
    total++; if (bus.count !== 3'd0) $display("FAIL rst_count got %0d exp 0", bus.count); else passed++;
    rst = 1'b0;
    #1;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL rel_ready got %b exp 1", bus.in_ready); else passed++;
  endtask
  task automatic test_single();
    bus.in_valid = 1'b1; bus.in_rd = 5'd5; bus.in_data = 32'hDEADBEEF;
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.WE !== 1'b0) $display("FAIL single_nobypass got %b exp 0", bus.WE); else passed++;
    total++; if (bus.count !== 3'd1) $display("FAIL single_cnt1 got %0d exp 1", bus.count); else passed++;
    step();
    total++; if ({bus.WE, bus.Rw, bus.Di} !== {1'b1, 5'd5, 32'hDEADBEEF})
      $display("FAIL single_out got %b/%0d/%h exp 1/5/deadbeef", bus.WE, bus.Rw, bus.Di); else passed++;
    total++; if (bus.count !== 3'd0) $display("FAIL single_cnt0 got %0d exp 0", bus.count); else passed++;
    @(negedge clk); #1;
    total++; if (rf[5] !== 32'hDEADBEEF) $display("FAIL single_rf got %h exp deadbeef", rf[5]); else passed++;
    step();
    total++; if (bus.WE !== 1'b0) $display("FAIL single_we_off got %b exp 0", bus.WE); else passed++;
  endtask
  task automatic test_full();
    bus.hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.in_valid = 1'b1; bus.in_rd = 5'(i); bus.in_data = 32'h10 + 32'(i - 1);
      step();
    end
    total++; if (bus.count !== 3'd4) $display("FAIL full_count got %0d exp 4", bus.count); else passed++;
    total++; if (bus.in_ready !== 1'b0) $display("FAIL full_ready got %b exp 0", bus.in_ready); else passed++;
    bus.in_rd = 5'd9; bus.in_data = 32'h99;
    step();
    total++; if (bus.count !== 3'd4) $display("FAIL full_fifth got %0d exp 4", bus.count); else passed++;
    total++; if (bus.WE !== 1'b0) $display("FAIL full_hold_we got %b exp 0", bus.WE); else passed++;
    bus.in_valid = 1'b0; bus.hold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      total++; if ({bus.WE, bus.Rw, bus.Di} !== {1'b1, 5'(i), 32'h10 + 32'(i - 1)})
        $display("FAIL full_drain%0d got %b/%0d/%h exp 1/%0d/%h", i, bus.WE, bus.Rw, bus.Di, i, 32'h10 + 32'(i - 1));
      else passed++;
    end
    step();
    total++; if (bus.WE !== 1'b0) $display("FAIL full_end_we got %b exp 0", bus.WE); else passed++;
    total++; if (bus.Rw !== 5'd4) $display("FAIL full_rw_hold got %0d exp 4", bus.Rw); else passed++;
  endtask
  task automatic test_zero_reg();
    bus.in_valid = 1'b1; bus.in_rd = 5'd0; bus.in_data = 32'h1234; bus.Qa = 5'd0;
    #1;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL zero_ready got %b exp 1", bus.in_ready); else passed++;
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.count !== 3'd0) $display("FAIL zero_count got %0d exp 0", bus.count); else passed++;
    total++; if ({bus.hitA, bus.fwdA} !== 33'd0) $display("FAIL zero_lookup got %b/%h exp 0/0", bus.hitA, bus.fwdA); else passed++;
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (bus.WE !== 1'b0) $display("FAIL zero_we%0d got %b exp 0", i, bus.WE); else passed++;
    end
  endtask
  task automatic test_forwarding();
    bus.hold = 1'b1;
    bus.in_valid = 1'b1; bus.in_rd = 5'd7; bus.in_data = 32'h11;
    step();
    bus.in_data = 32'h22;
    step();
    bus.in_valid = 1'b0; bus.Qa = 5'd7; bus.Qb = 5'd8;
    #1;
    total++; if ({bus.hitA, bus.fwdA} !== {1'b1, 32'h22}) $display("FAIL fwd_pre got %b/%h exp 1/22", bus.hitA, bus.fwdA); else passed++;
    total++; if ({bus.hitB, bus.fwdB} !== 33'd0) $display("FAIL fwd_b got %b/%h exp 0/0", bus.hitB, bus.fwdB); else passed++;
    bus.hold = 1'b0;
    step();
    bus.hold = 1'b1;
    total++; if ({bus.WE, bus.Rw, bus.Di} !== {1'b1, 5'd7, 32'h11}) $display("FAIL fwd_first got %b/%0d/%h exp 1/7/11", bus.WE, bus.Rw, bus.Di); else passed++;
    total++; if ({bus.hitA, bus.fwdA} !== {1'b1, 32'h22}) $display("FAIL fwd_mid got %b/%h exp 1/22", bus.hitA, bus.fwdA); else passed++;
    step();
    total++; if ({bus.hitA, bus.fwdA} !== {1'b1, 32'h22}) $display("FAIL fwd_held got %b/%h exp 1/22", bus.hitA, bus.fwdA); else passed++;
    bus.hold = 1'b0;
    step();
    total++; if ({bus.WE, bus.Di, bus.count} !== {1'b1, 32'h22, 3'd0}) $display("FAIL fwd_second got %b/%h/%0d exp 1/22/0", bus.WE, bus.Di, bus.count); else passed++;
    total++; if ({bus.hitA, bus.fwdA} !== {1'b1, 32'h22}) $display("FAIL fwd_outreg got %b/%h exp 1/22", bus.hitA, bus.fwdA); else passed++;
    step();
    total++; if ({bus.hitA, bus.fwdA} !== 33'd0) $display("FAIL fwd_gone got %b/%h exp 0/0", bus.hitA, bus.fwdA); else passed++;
  endtask
  task automatic test_back_to_back();
    bus.hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.in_rd = 5'(20 + i); bus.in_data = 32'hA0 + 32'(i);
      step();
      total++; if (bus.count !== 3'd1) $display("FAIL b2b_count%0d got %0d exp 1", i, bus.count); else passed++;
      if (i > 0) begin
        total++; if ({bus.WE, bus.Rw, bus.Di} !== {1'b1, 5'(19 + i), 32'hA0 + 32'(i - 1)})
          $display("FAIL b2b_out%0d got %b/%0d/%h exp 1/%0d/%h", i, bus.WE, bus.Rw, bus.Di, 19 + i, 32'hA0 + 32'(i - 1));
        else passed++;
      end
    end
    bus.in_valid = 1'b0;
    step();
    total++; if ({bus.WE, bus.Rw, bus.Di, bus.count} !== {1'b1, 5'd23, 32'hA3, 3'd0})
      $display("FAIL b2b_last got %b/%0d/%h/%0d exp 1/23/a3/0", bus.WE, bus.Rw, bus.Di, bus.count); else passed++;
    step();
  endtask
  task automatic test_reset_mid();
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_rd = 5'(10 + i); bus.in_data = 32'hC0 + 32'(i);
      step();
    end
    bus.in_valid = 1'b0; bus.hold = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (bus.count !== 3'd0) $display("FAIL mid_count got %0d exp 0", bus.count); else passed++;
    for (int i = 0; i < 5; i++) begin
      total++; if (bus.WE !== 1'b0) $display("FAIL mid_we%0d got %b exp 0", i, bus.WE); else passed++;
      step();
    end
  endtask
  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_rd = '0; bus.in_data = '0; bus.hold = 1'b0; bus.Qa = '0; bus.Qb = '0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    test_reset();
    test_single();
    test_full();
    test_zero_reg();
    test_forwarding();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
